// File: rtl/pcie_slv_pkg.sv
// Shared constants for the pcie_tlp slave-bus register/memory target:
// bus widths, read-source tags and register-map offsets.
package pcie_slv_pkg;

  localparam int DW = 16;
  localparam int SW = 2;
  localparam int IW = 9;

  typedef enum logic {
    SRC_REG = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

  // Register map: control words first, then status, doorbell, counter pair.
  function automatic int stat_base(input int num_ctrl);
    return num_ctrl;
  endfunction

  function automatic int doorbell_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat;
  endfunction

  function automatic int cnt_lo_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat + 1;
  endfunction

  function automatic int cnt_hi_idx(input int num_ctrl, input int num_stat);
    return num_ctrl + num_stat + 2;
  endfunction

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old,
                                               input logic [DW-1:0] dat,
                                               input logic [SW-1:0] sel);
    logic [DW-1:0] res;
    res[7:0]  = sel[0] ? dat[7:0]  : old[7:0];
    res[15:8] = sel[1] ? dat[15:8] : old[15:8];
    return res;
  endfunction

endpackage

// File: rtl/pcie_slv_rdpipe.sv
// Read-return delay line: valid/source tags and register data travel MEM_LAT
// stages; memory data is taken live from the RAM at the last stage.
module pcie_slv_rdpipe
  import pcie_slv_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic          clk_125,
  input  logic          rstn,
  input  logic          in_vld,
  input  logic          in_src,
  input  logic [DW-1:0] in_dat,
  input  logic [DW-1:0] mem_q,
  output logic          ack,
  output logic [DW-1:0] dat
);

  logic [MEM_LAT-1:0] vld_p;
  logic [MEM_LAT-1:0] src_p;
  logic [DW-1:0]      dat_p [MEM_LAT];

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      vld_p <= '0;
      src_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      src_p[0] <= in_src;
      for (int i = 1; i < MEM_LAT; i++) begin
        vld_p[i] <= vld_p[i-1];
        src_p[i] <= src_p[i-1];
      end
    end
  end

  // data stages carry no reset; the output mux masks them with the valid tag
  always_ff @(posedge clk_125) begin
    dat_p[0] <= in_dat;
    for (int i = 1; i < MEM_LAT; i++) dat_p[i] <= dat_p[i-1];
  end

  assign ack = rstn & vld_p[MEM_LAT-1];

  always_comb begin
    dat = '0;
    if (ack) dat = (src_p[MEM_LAT-1] == SRC_MEM) ? mem_q : dat_p[MEM_LAT-1];
  end

endmodule

// File: rtl/pcie_slv_regbank.sv
// Slave-bus target: control/status/doorbell register BAR plus forwarded memory BAR.
// Define PCIE_SLV_CYCLE_CNT_EN to add the CNT_LO/CNT_HI free-running cycle counter.
module pcie_slv_regbank
  import pcie_slv_pkg::*;
#(
  parameter int            NUM_CTRL = 4,
  parameter int            NUM_STAT = 2,
  parameter int            REG_BAR  = 0,
  parameter int            MEM_BAR  = 2,
  parameter int            MEM_AW   = 14,
  parameter int            MEM_LAT  = 1,
  parameter logic [DW-1:0] CTRL_RST = 16'h0000,
  localparam int           STAT_N   = (NUM_STAT > 0) ? NUM_STAT : 1
) (
  input  logic                   clk_125,
  input  logic                   rstn,
  input  logic [6:0]             slv_bar_i,
  input  logic                   slv_ce_i,
  input  logic                   slv_we_i,
  input  logic [19:1]            slv_adr_i,
  input  logic [DW-1:0]          slv_dat_i,
  input  logic [SW-1:0]          slv_sel_i,
  output logic [DW-1:0]          slv_dat_o,
  output logic                   slv_ack_o,
  output logic [DW*NUM_CTRL-1:0] ctrl_o,
  input  logic [DW*STAT_N-1:0]   stat_i,
  output logic [DW-1:0]          doorbell_o,
  output logic                   mem_ce_o,
  output logic                   mem_we_o,
  output logic [MEM_AW-1:0]      mem_adr_o,
  output logic [SW-1:0]          mem_be_o,
  output logic [DW-1:0]          mem_dat_o,
  input  logic [DW-1:0]          mem_q_i
);

  localparam logic [IW-1:0] STAT_BASE    = IW'(stat_base(NUM_CTRL));
  localparam logic [IW-1:0] DOORBELL_IDX = IW'(doorbell_idx(NUM_CTRL, NUM_STAT));

  logic          reg_hit;
  logic          mem_hit;
  logic          reg_wr;
  logic          rd_vld;
  logic          rd_src;
  logic [IW-1:0] idx;
  logic [DW-1:0] ctrl_q [NUM_CTRL];
  logic [DW-1:0] doorbell_q;
  logic [DW-1:0] reg_rdata;
  logic          unused_ok;

  // register BAR wins when both bar-hit bits are raised
  assign reg_hit = slv_ce_i & slv_bar_i[REG_BAR];
  assign mem_hit = slv_ce_i & slv_bar_i[MEM_BAR] & ~slv_bar_i[REG_BAR];
  assign idx     = slv_adr_i[9:1];
  assign reg_wr  = reg_hit & slv_we_i;
  assign rd_vld  = (reg_hit | mem_hit) & ~slv_we_i;
  assign rd_src  = reg_hit ? SRC_REG : SRC_MEM;

  assign mem_ce_o  = mem_hit;
  assign mem_we_o  = mem_hit & slv_we_i;
  assign mem_adr_o = slv_adr_i[MEM_AW:1];
  assign mem_be_o  = slv_sel_i;
  assign mem_dat_o = slv_dat_i;

  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_CTRL; k++) ctrl_q[k] <= CTRL_RST;
      doorbell_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (reg_wr && idx == IW'(k)) ctrl_q[k] <= byte_merge(ctrl_q[k], slv_dat_i, slv_sel_i);
      end
      doorbell_q <= (reg_wr && idx == DOORBELL_IDX) ?
                    byte_merge('0, slv_dat_i, slv_sel_i) : '0;
    end
  end

  for (genvar g = 0; g < NUM_CTRL; g++) begin : g_ctrl
    assign ctrl_o[DW*g +: DW] = ctrl_q[g];
  end

  assign doorbell_o = doorbell_q;

`ifdef PCIE_SLV_CYCLE_CNT_EN
  localparam logic [IW-1:0] CNT_LO_IDX = IW'(cnt_lo_idx(NUM_CTRL, NUM_STAT));
  localparam logic [IW-1:0] CNT_HI_IDX = IW'(cnt_hi_idx(NUM_CTRL, NUM_STAT));

  logic          reg_rd;
  logic [31:0]   cnt_q;
  logic [DW-1:0] shadow_q;

  assign reg_rd = reg_hit & ~slv_we_i;

  // the high half is frozen at the low-half read so a 32-bit pair is coherent
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      shadow_q <= '0;
    end else begin
      cnt_q <= (reg_wr && idx == CNT_LO_IDX) ? '0 : cnt_q + 32'd1;
      if (reg_rd && idx == CNT_LO_IDX) shadow_q <= cnt_q[31:16];
    end
  end
`endif

  always_comb begin
    reg_rdata = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (idx == IW'(k)) reg_rdata = ctrl_q[k];
    end
    for (int s = 0; s < NUM_STAT; s++) begin
      if (idx == STAT_BASE + IW'(s)) reg_rdata = stat_i[DW*s +: DW];
    end
`ifdef PCIE_SLV_CYCLE_CNT_EN
    if (idx == CNT_LO_IDX) reg_rdata = cnt_q[15:0];
    if (idx == CNT_HI_IDX) reg_rdata = shadow_q;
`endif
  end

  // address bits beyond both decoders and the pad word of stat_i are don't-care
  assign unused_ok = ^{slv_adr_i, stat_i};

  pcie_slv_rdpipe #(
    .MEM_LAT (MEM_LAT)
  ) u_rdpipe (
    .clk_125 (clk_125),
    .rstn    (rstn),
    .in_vld  (rd_vld),
    .in_src  (rd_src),
    .in_dat  (reg_rdata),
    .mem_q   (mem_q_i),
    .ack     (slv_ack_o),
    .dat     (slv_dat_o)
  );

endmodule

// File: tb/tb_pcie_slv_regbank.sv
// Bench for pcie_slv_regbank: directed vector table, multi-cycle sequences and
// a randomized run scored against a register/memory reference model.
module tb_pcie_slv_regbank;
  import pcie_slv_pkg::*;

  localparam int NUM_CTRL = 4;
  localparam int NUM_STAT = 2;
  localparam int REG_BAR  = 0;
  localparam int MEM_BAR  = 2;
  localparam int MEM_AW   = 14;
  localparam int MEM_LAT  = 3;
  localparam logic [15:0] CTRL_RST = 16'h0000;
  localparam int DB_IDX = NUM_CTRL + NUM_STAT;
  localparam logic [6:0] B_REG  = 7'b0000001;
  localparam logic [6:0] B_MEM  = 7'b0000100;
  localparam logic [6:0] B_BOTH = 7'b0000101;
  localparam logic [6:0] B_NONE = 7'b0000010;
  localparam int K_RD = 0, K_CTRL = 1, K_DB = 2, K_NONE = 3;

  logic        clk_125 = 1'b0;
  logic        rstn = 1'b0;
  logic [6:0]  slv_bar_i = '0;
  logic        slv_ce_i = 1'b0;
  logic        slv_we_i = 1'b0;
  logic [19:1] slv_adr_i = '0;
  logic [15:0] slv_dat_i = '0;
  logic [1:0]  slv_sel_i = '0;
  logic [15:0] slv_dat_o;
  logic        slv_ack_o;
  logic [63:0] ctrl_o;
  logic [31:0] stat_i = '0;
  logic [15:0] doorbell_o;
  logic        mem_ce_o, mem_we_o;
  logic [MEM_AW-1:0] mem_adr_o;
  logic [1:0]  mem_be_o;
  logic [15:0] mem_dat_o, mem_q_i;

  int checks = 0;
  int passed = 0;

  pcie_slv_regbank #(
    .NUM_CTRL(NUM_CTRL), .NUM_STAT(NUM_STAT), .REG_BAR(REG_BAR), .MEM_BAR(MEM_BAR),
    .MEM_AW(MEM_AW), .MEM_LAT(MEM_LAT), .CTRL_RST(CTRL_RST)
  ) dut (
    .clk_125(clk_125), .rstn(rstn), .slv_bar_i(slv_bar_i), .slv_ce_i(slv_ce_i),
    .slv_we_i(slv_we_i), .slv_adr_i(slv_adr_i), .slv_dat_i(slv_dat_i), .slv_sel_i(slv_sel_i),
    .slv_dat_o(slv_dat_o), .slv_ack_o(slv_ack_o), .ctrl_o(ctrl_o), .stat_i(stat_i),
    .doorbell_o(doorbell_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
    .mem_be_o(mem_be_o), .mem_dat_o(mem_dat_o), .mem_q_i(mem_q_i)
  );

  always #4 clk_125 = ~clk_125;

  // external RAM with MEM_LAT cycles of read latency
  bit   [15:0] ram [1<<MEM_AW];
  logic [15:0] rq  [MEM_LAT];
  always @(posedge clk_125) begin
    if (mem_ce_o && mem_we_o) begin
      if (mem_be_o[0]) ram[mem_adr_o][7:0]  <= mem_dat_o[7:0];
      if (mem_be_o[1]) ram[mem_adr_o][15:8] <= mem_dat_o[15:8];
    end
    rq[0] <= ram[mem_adr_o];
    for (int i = 1; i < MEM_LAT; i++) rq[i] <= rq[i-1];
  end
  assign mem_q_i = rq[MEM_LAT-1];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] bmerge(input logic [15:0] old, input logic [15:0] d,
                                         input logic [1:0] s);
    return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk_125);
    #1;
  endtask

  task automatic drive(input logic [6:0] bar, input logic we, input logic [18:0] adr,
                       input logic [15:0] dat, input logic [1:0] sel);
    slv_ce_i = 1'b1; slv_bar_i = bar; slv_we_i = we;
    slv_adr_i = adr; slv_dat_i = dat; slv_sel_i = sel;
  endtask

  task automatic idle;
    slv_ce_i = 1'b0; slv_bar_i = '0; slv_we_i = 1'b0;
    slv_adr_i = '0; slv_dat_i = '0; slv_sel_i = '0;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  bar;
    logic        we;
    logic [18:0] adr;
    logic [15:0] dat;
    logic [1:0]  sel;
    int          kind;
    int          word;
    logic [15:0] exp;
    logic        mce;
  } vec_t;

  task automatic apply(input vec_t v);
    drive(v.bar, v.we, v.adr, v.dat, v.sel);
    #1 chk({v.name, "_mem_ce"}, 64'(mem_ce_o), 64'(v.mce));
    tick; idle();
    case (v.kind)
      K_CTRL: chk(v.name, 64'(ctrl_o[16*v.word +: 16]), 64'(v.exp));
      K_DB: begin
        chk(v.name, 64'(doorbell_o), 64'(v.exp));
        tick;
        chk({v.name, "_clr"}, 64'(doorbell_o), 64'h0);
      end
      K_RD: begin
        for (int k = 1; k < MEM_LAT; k++) begin
          chk({v.name, "_early_ack"}, 64'(slv_ack_o), 64'h0);
          tick;
        end
        chk({v.name, "_ack"}, 64'(slv_ack_o), 64'h1);
        chk({v.name, "_dat"}, 64'(slv_dat_o), 64'(v.exp));
        tick;
        chk({v.name, "_ack_end"}, 64'(slv_ack_o), 64'h0);
        chk({v.name, "_dat_end"}, 64'(slv_dat_o), 64'h0);
      end
      default: ;
    endcase
    tick;
  endtask

  task automatic rd_check(input string name, input logic [18:0] adr, input logic [15:0] exp);
    drive(B_REG, 1'b0, adr, '0, '0);
    tick; idle();
    repeat (MEM_LAT - 1) tick;
    chk({name, "_ack"}, 64'(slv_ack_o), 64'h1);
    chk({name, "_dat"}, 64'(slv_dat_o), 64'(exp));
  endtask

  typedef struct { int due; logic [15:0] val; } exp_t;
  exp_t        sb [$];
  logic [15:0] ctrl_m [NUM_CTRL];
  logic [15:0] mem_m  [16];
  vec_t        vt     [16];

  initial begin
    vt[0]  = '{"ctrl1_wr_lo",   B_REG,  1'b1, 19'd1, 16'hA5C3, 2'b01, K_CTRL, 1, 16'h00C3, 1'b0};
    vt[1]  = '{"ctrl1_rd",      B_REG,  1'b0, 19'd1, 16'h0000, 2'b00, K_RD,   0, 16'h00C3, 1'b0};
    vt[2]  = '{"ctrl1_rd_hiadr",B_REG,  1'b0, {10'h3A5, 9'd1}, 16'h0, 2'b00, K_RD, 0, 16'h00C3, 1'b0};
    vt[3]  = '{"ctrl1_wr_hi",   B_REG,  1'b1, 19'd1, 16'h7700, 2'b10, K_CTRL, 1, 16'h77C3, 1'b0};
    vt[4]  = '{"ctrl2_bothbar", B_BOTH, 1'b1, 19'd2, 16'hBEEF, 2'b11, K_CTRL, 2, 16'hBEEF, 1'b0};
    vt[5]  = '{"ctrl3_nobar",   B_NONE, 1'b1, 19'd3, 16'h1111, 2'b11, K_CTRL, 3, CTRL_RST, 1'b0};
    vt[6]  = '{"ctrl0_memonly", B_MEM,  1'b1, 19'd0, 16'h4444, 2'b11, K_CTRL, 0, CTRL_RST, 1'b1};
    vt[7]  = '{"db_full",       B_REG,  1'b1, 19'(DB_IDX), 16'h8001, 2'b11, K_DB, 0, 16'h8001, 1'b0};
    vt[8]  = '{"db_hi",         B_REG,  1'b1, 19'(DB_IDX), 16'h1234, 2'b10, K_DB, 0, 16'h1200, 1'b0};
    vt[9]  = '{"db_nosel",      B_REG,  1'b1, 19'(DB_IDX), 16'hFFFF, 2'b00, K_DB, 0, 16'h0000, 1'b0};
    vt[10] = '{"stat0_rd",      B_REG,  1'b0, 19'd4, 16'h0, 2'b00, K_RD, 0, 16'h1111, 1'b0};
    vt[11] = '{"stat1_rd",      B_REG,  1'b0, 19'd5, 16'h0, 2'b00, K_RD, 0, 16'h2222, 1'b0};
    vt[12] = '{"db_rd",         B_REG,  1'b0, 19'(DB_IDX), 16'h0, 2'b00, K_RD, 0, 16'h0000, 1'b0};
    vt[13] = '{"unmapped_rd",   B_REG,  1'b0, 19'd300, 16'h0, 2'b00, K_RD, 0, 16'h0000, 1'b0};
    vt[14] = '{"mem_wr",        B_MEM,  1'b1, 19'd5, 16'h1234, 2'b11, K_NONE, 0, 16'h0, 1'b1};
    vt[15] = '{"mem_rd",        B_MEM,  1'b0, 19'd5, 16'h0, 2'b00, K_RD, 0, 16'h1234, 1'b1};

    // reset state
    idle();
    repeat (3) @(posedge clk_125);
    #1;
    chk("rst_ctrl", ctrl_o, {4{CTRL_RST}});
    chk("rst_ack", 64'(slv_ack_o), 64'h0);
    chk("rst_dat", 64'(slv_dat_o), 64'h0);
    chk("rst_doorbell", 64'(doorbell_o), 64'h0);
    chk("rst_mem_ce", 64'(mem_ce_o), 64'h0);
    rstn = 1'b1;
    tick;

    stat_i = {16'h2222, 16'h1111};
    for (int i = 0; i < 16; i++) apply(vt[i]);

    // back-to-back reads from mixed sources
    drive(B_REG, 1'b0, 19'd0, '0, '0);   tick;
    drive(B_MEM, 1'b0, 19'd5, '0, '0);   tick;
    drive(B_REG, 1'b0, 19'd20, '0, '0);  tick; idle();
    chk("b2b_ack0", 64'(slv_ack_o), 64'h1);
    chk("b2b_dat0", 64'(slv_dat_o), 64'h0);
    tick;
    chk("b2b_ack1", 64'(slv_ack_o), 64'h1);
    chk("b2b_dat1", 64'(slv_dat_o), 64'h1234);
    tick;
    chk("b2b_ack2", 64'(slv_ack_o), 64'h1);
    chk("b2b_dat2", 64'(slv_dat_o), 64'h0);
    tick;
    chk("b2b_ack_end", 64'(slv_ack_o), 64'h0);

    // a write slotted between two reads
    drive(B_REG, 1'b0, 19'd1, '0, '0);         tick;
    drive(B_REG, 1'b1, 19'd0, 16'h0F0F, 2'b11); tick;
    drive(B_REG, 1'b0, 19'd0, '0, '0);         tick; idle();
    chk("wbr_ack_a", 64'(slv_ack_o), 64'h1);
    chk("wbr_dat_a", 64'(slv_dat_o), 64'h77C3);
    tick;
    chk("wbr_gap", 64'(slv_ack_o), 64'h0);
    tick;
    chk("wbr_ack_b", 64'(slv_ack_o), 64'h1);
    chk("wbr_dat_b", 64'(slv_dat_o), 64'h0F0F);
    tick;

    // back-to-back doorbell pulses
    drive(B_REG, 1'b1, 19'(DB_IDX), 16'h0001, 2'b11); tick;
    chk("db_b2b_0", 64'(doorbell_o), 64'h0001);
    drive(B_REG, 1'b1, 19'(DB_IDX), 16'h0002, 2'b11); tick; idle();
    chk("db_b2b_1", 64'(doorbell_o), 64'h0002);
    tick;
    chk("db_b2b_clr", 64'(doorbell_o), 64'h0);

`ifdef PCIE_SLV_CYCLE_CNT_EN
    drive(B_REG, 1'b1, 19'(DB_IDX + 1), 16'hFFFF, 2'b11); tick; idle();
    repeat (65534) tick;
    rd_check("cnt_lo_prewrap", 19'(DB_IDX + 1), 16'hFFFE);
    rd_check("cnt_hi_shadow", 19'(DB_IDX + 2), 16'h0000);
    rd_check("cnt_lo_wrapped", 19'(DB_IDX + 1), 16'h0004);
    rd_check("cnt_hi_after", 19'(DB_IDX + 2), 16'h0001);
    drive(B_REG, 1'b1, 19'(DB_IDX + 1), 16'h0, 2'b00); tick;
    rd_check("cnt_restart", 19'(DB_IDX + 1), 16'h0000);
    rd_check("cnt_run", 19'(DB_IDX + 1), 16'h0003);
`endif

    // reset between a read and its ack
    drive(B_REG, 1'b0, 19'd1, '0, '0); tick; idle();
    #1 rstn = 1'b0;
    #1 chk("mid_rst_ctrl", ctrl_o, {4{CTRL_RST}});
    chk("mid_rst_ack", 64'(slv_ack_o), 64'h0);
    rstn = 1'b1;
    for (int k = 0; k < MEM_LAT + 2; k++) begin
      tick;
      chk("flush_no_ack", 64'(slv_ack_o), 64'h0);
    end

    // randomized traffic against the reference model
    for (int i = 0; i < NUM_CTRL; i++) ctrl_m[i] = CTRL_RST;
    for (int i = 0; i < 16; i++) mem_m[i] = '0;
    for (int c = 0; c < 600; c++) begin
      logic [6:0]  bar;
      logic        we, ce, rh, mh;
      logic [18:0] adr;
      logic [15:0] dat, rv, db_exp;
      logic [1:0]  sel;
      logic [8:0]  idx;
      ce  = (c < 590) && ($urandom_range(0, 3) != 0);
      bar = 7'($urandom_range(0, 127));
      we  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      dat = 16'($urandom);
      idx = 9'($urandom_range(0, 11));
`ifdef PCIE_SLV_CYCLE_CNT_EN
      if (idx == 9'(DB_IDX + 1) || idx == 9'(DB_IDX + 2)) idx = 9'd11;
`endif
      rh = ce && bar[REG_BAR];
      mh = ce && bar[MEM_BAR] && !bar[REG_BAR];
      if (mh) adr = {5'($urandom), 14'(64 + $urandom_range(0, 15))};
      else    adr = {10'($urandom), idx};
      stat_i = $urandom;
      if (ce) drive(bar, we, adr, dat, sel);
      else    idle();
      #1 chk("rnd_mem_ce", 64'(mem_ce_o), 64'(mh));
      if (mh) begin
        chk("rnd_mem_we", 64'(mem_we_o), 64'(we));
        chk("rnd_mem_adr", 64'(mem_adr_o), 64'(adr[13:0]));
      end
      db_exp = '0;
      if (rh && we) begin
        if (idx < 9'(NUM_CTRL)) ctrl_m[idx[1:0]] = bmerge(ctrl_m[idx[1:0]], dat, sel);
        else if (idx == 9'(DB_IDX)) db_exp = bmerge(16'h0, dat, sel);
      end else if (rh) begin
        rv = '0;
        if (idx < 9'(NUM_CTRL)) rv = ctrl_m[idx[1:0]];
        else if (idx == 9'd4) rv = stat_i[15:0];
        else if (idx == 9'd5) rv = stat_i[31:16];
        sb.push_back('{c + MEM_LAT, rv});
      end else if (mh && we) begin
        mem_m[adr[3:0]] = bmerge(mem_m[adr[3:0]], dat, sel);
      end else if (mh) begin
        sb.push_back('{c + MEM_LAT, mem_m[adr[3:0]]});
      end
      tick;
      chk("rnd_doorbell", 64'(doorbell_o), 64'(db_exp));
      chk("rnd_ctrl", ctrl_o, {ctrl_m[3], ctrl_m[2], ctrl_m[1], ctrl_m[0]});
      if (sb.size() > 0 && sb[0].due == c + 1) begin
        chk("rnd_ack", 64'(slv_ack_o), 64'h1);
        chk("rnd_dat", 64'(slv_dat_o), 64'(sb[0].val));
        void'(sb.pop_front());
      end else begin
        chk("rnd_noack", 64'(slv_ack_o), 64'h0);
        chk("rnd_dat_idle", 64'(slv_dat_o), 64'h0);
      end
    end
    chk("rnd_drained", 64'(sb.size()), 64'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
